video_timing_generator: RTL and testbench
=========================================

# video_timing_generator

Generates raster timing for the HDMI/DVI output path: horizontal/vertical counters, pixel fetch requests toward the frame source, and the aligned per-channel pixel, display-enable and control-bus signals. All are consumed directly by the three `synchronous_encoder_serializer` instances. A fixed fetch-latency pipeline keeps returned pixel data and sync/DE signals cycle-aligned. A run/idle state machine starts and stops video only on frame boundaries.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low
- FETCH_LATENCY, 2, cycles from fetch request to valid pixelIn data; legal range 1..8

Ports:
- pixelClock  in  1  pixel clock; sole clock, all logic on rising edge
- resetN  in  1  synchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundary
- pixelIn  in  24  {R,G,B} from frame source, valid FETCH_LATENCY cycles after the matching fetch request
- fetchActive  out  1  fetchX/fetchY address a visible pixel
- fetchX  out  11  column of requested pixel
- fetchY  out  10  row of requested pixel
- frameStart  out  1  one-cycle pulse on first fetch cycle of each frame
- DE  out  1  display enable to all encoders
- controlBus  out  2  {vsync,hsync} for blue channel; red/green channels tie to 2'b00
- redOut, greenOut, blueOut  out  8 each  pixel components to encoders

## Operation
- Line: hCount 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). Active is hCount < H_ACTIVE; hsync asserted for H_ACTIVE+H_FRONT ≤ hCount < H_ACTIVE+H_FRONT+H_SYNC.
- Frame: vCount 0..V_TOTAL-1 (525), incremented when hCount wraps. Vertical regions are ordered the same way as horizontal ones. vsync changes on hCount wrap only.
- Fetch stage (registered from counters):
  - fetchActive = hActive && vActive
  - fetchX = hCount, fetchY = vCount when active, else 0
- Output stage: {fetchActive, hsync, vsync} passes through a FETCH_LATENCY-deep shift register.
  - DE = delayed fetchActive.
  - redOut/greenOut/blueOut = pixelIn when delayed fetchActive is high, else 0.
  - controlBus drives sync levels with SYNC_ACTIVE_LOW polarity applied.
- State machine:
  - IDLE: counters held at 0; DE 0, syncs inactive. Go to RUN when enable = 1.
  - RUN: counters free-run. At the last cycle of the frame (hCount = H_TOTAL-1, vCount = V_TOTAL-1), if enable = 0, go to IDLE; otherwise wrap to (0,0).
  - Deasserting enable mid-frame has no effect until the frame completes.
- Widths: counters 11/10 bits. The generator must flag an elaboration error if H_TOTAL > 2048, V_TOTAL > 1024, or FETCH_LATENCY is out of range.

## Timing
- Reset values:
  - state IDLE, counters 0, whole pipeline cleared
  - fetchActive 0, fetchX/fetchY 0, frameStart 0
  - DE 0, colour outputs 0
  - controlBus = inactive level: 2'b11 if SYNC_ACTIVE_LOW, else 2'b00
- Reset mid-frame: all reset values apply on the cycle after the resetN-low edge. Pipeline contents are discarded, with no partial DE pulse.
- Start latency:
  - enable rises at cycle N (IDLE) → RUN at N+1, counters (0,0) at N+1.
  - fetchActive and frameStart high at N+2.
  - DE high at N+2+FETCH_LATENCY.
- Fetch → output latency is exactly FETCH_LATENCY cycles for every signal, so DE, syncs and pixel data stay mutually aligned.
- frameStart coincides with fetchActive for (0,0) and is never asserted in IDLE.
- enable toggling within one frame has no effect. Simultaneous enable = 0 and frame wrap means the next cycle is IDLE.

## Structure
- Package `video_timing_pkg`:
  - 640x480@60 and 1280x720@60 timing constant sets
  - counter width constants
  - state enum {IDLE, RUN}
  - sync polarity helper
- Sub-module `signal_delay_line` (parameter WIDTH, DEPTH; reset to a parameterised INIT value) implements the output pipeline.

## Test plan
- Reset, enable = 1 from start → frameStart every 420000 cycles. DE high exactly 640 consecutive cycles per visible line, 480 lines per frame, then 45 lines of DE = 0.
- Default params → hsync low for 96 cycles starting 16 cycles after the line's last DE. vsync low for 2×800 cycles starting at line 490.
- FETCH_LATENCY = 3, pixelIn = {fetchX[7:0], fetchY[7:0], 8'hA5} fed back through a 3-cycle model → redOut equals column, greenOut equals row, for every DE cycle. Colour outputs are 0 whenever DE = 0.
- Deassert enable at line 100 → frame completes through line 524. Generator enters IDLE with DE 0 and controlBus 2'b11. Re-assert → frameStart 2 cycles later.
- resetN low at (hCount 300, vCount 200) → next cycle all outputs at reset values. No DE pulse emerges from the flushed pipeline.
- SYNC_ACTIVE_LOW = 0 with 1280x720 constants → controlBus idles 2'b00. hsync high 40 cycles per 1650-cycle line, frame of 750 lines.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, counter widths, run/idle state and sync helpers
// for the HDMI/DVI video timing generator.
package video_timing_pkg;

   // 640x480 @ 60 Hz
   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FRONT  = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BACK   = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FRONT  = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BACK   = 33;

   // 1280x720 @ 60 Hz
   localparam int unsigned HD_H_ACTIVE = 1280;
   localparam int unsigned HD_H_FRONT  = 110;
   localparam int unsigned HD_H_SYNC   = 40;
   localparam int unsigned HD_H_BACK   = 220;
   localparam int unsigned HD_V_ACTIVE = 720;
   localparam int unsigned HD_V_FRONT  = 5;
   localparam int unsigned HD_V_SYNC   = 5;
   localparam int unsigned HD_V_BACK   = 20;

   localparam int unsigned H_CNT_W   = 11;
   localparam int unsigned V_CNT_W   = 10;
   localparam int unsigned H_CNT_MAX = 2048;
   localparam int unsigned V_CNT_MAX = 1024;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } vtgState_e;

   // Control word carried alongside each fetch through the latency pipeline.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } videoCtl_t;

   localparam int unsigned VIDEO_CTL_W = $bits(videoCtl_t);

   // Wire level of a sync signal given its logical state and polarity.
   function automatic logic syncLevel(input logic asserted, input logic activeLow);
      return asserted ^ activeLow;
   endfunction

endpackage

// File: rtl/video_timing_generator_signal_delay_line.sv
// Fixed-depth shift register that resets every stage to a programmable value.
module signal_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut
);

   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clock) begin
      if (!resetN) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            stages[i] <= INIT;
         end
      end else begin
         stages[0] <= dataIn;
         for (int i = 1; i < int'(DEPTH); i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign dataOut = stages[DEPTH-1];

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: h/v counters, pixel fetch requests and latency-aligned
// DE / sync / colour outputs for the three TMDS encoder channels.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
   parameter int unsigned H_FRONT         = VGA_H_FRONT,
   parameter int unsigned H_SYNC          = VGA_H_SYNC,
   parameter int unsigned H_BACK          = VGA_H_BACK,
   parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
   parameter int unsigned V_FRONT         = VGA_V_FRONT,
   parameter int unsigned V_SYNC          = VGA_V_SYNC,
   parameter int unsigned V_BACK          = VGA_V_BACK,
   parameter int unsigned SYNC_ACTIVE_LOW = 1,
   parameter int unsigned FETCH_LATENCY   = 2
) (
   input  logic                 pixelClock,
   input  logic                 resetN,
   input  logic                 enable,
   input  logic [23:0]          pixelIn,
   output logic                 fetchActive,
   output logic [H_CNT_W-1:0]   fetchX,
   output logic [V_CNT_W-1:0]   fetchY,
   output logic                 frameStart,
   output logic                 DE,
   output logic [1:0]           controlBus,
   output logic [7:0]           redOut,
   output logic [7:0]           greenOut,
   output logic [7:0]           blueOut
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam logic        SYNC_LOW     = (SYNC_ACTIVE_LOW != 0);
   localparam logic [VIDEO_CTL_W-1:0] PIPE_INIT = {1'b0, SYNC_LOW, SYNC_LOW};

   if (H_TOTAL > H_CNT_MAX) begin : gHTotalTooLarge
      $error("video_timing_generator: H_TOTAL exceeds 2048");
   end
   if (V_TOTAL > V_CNT_MAX) begin : gVTotalTooLarge
      $error("video_timing_generator: V_TOTAL exceeds 1024");
   end
   if (FETCH_LATENCY < 1 || FETCH_LATENCY > 8) begin : gLatencyOutOfRange
      $error("video_timing_generator: FETCH_LATENCY must be 1..8");
   end

   vtgState_e           state;
   logic [H_CNT_W-1:0]  hCount;
   logic [V_CNT_W-1:0]  vCount;
   videoCtl_t           fetchCtl;
   videoCtl_t           pipeIn;
   videoCtl_t           pipeOut;

   logic lastH;
   logic lastV;
   logic running;
   logic hActive;
   logic vActive;
   logic hSyncRegion;
   logic vSyncRegion;

   assign lastH       = (32'(hCount) == H_TOTAL - 1);
   assign lastV       = (32'(vCount) == V_TOTAL - 1);
   assign running     = (state == RUN);
   assign hActive     = (32'(hCount) < H_ACTIVE);
   assign vActive     = (32'(vCount) < V_ACTIVE);
   assign hSyncRegion = (32'(hCount) >= H_SYNC_START) && (32'(hCount) < H_SYNC_END);
   assign vSyncRegion = (32'(vCount) >= V_SYNC_START) && (32'(vCount) < V_SYNC_END);

   // Run/idle control and raster counters; stopping only takes effect at frame end.
   always_ff @(posedge pixelClock) begin
      if (!resetN) begin
         state  <= IDLE;
         hCount <= '0;
         vCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               hCount <= '0;
               vCount <= '0;
               if (enable) state <= RUN;
            end
            RUN: begin
               if (lastH) begin
                  hCount <= '0;
                  if (lastV) begin
                     vCount <= '0;
                     if (!enable) state <= IDLE;
                  end else begin
                     vCount <= vCount + V_CNT_W'(1);
                  end
               end else begin
                  hCount <= hCount + H_CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Fetch stage: request address plus the raw control bits that travel with it.
   always_ff @(posedge pixelClock) begin
      if (!resetN) begin
         fetchCtl   <= '0;
         fetchX     <= '0;
         fetchY     <= '0;
         frameStart <= 1'b0;
      end else begin
         fetchCtl.active <= running && hActive && vActive;
         fetchCtl.hsync  <= running && hSyncRegion;
         fetchCtl.vsync  <= running && vSyncRegion;
         frameStart      <= running && (hCount == '0) && (vCount == '0);
         fetchX          <= (running && hActive && vActive) ? hCount : '0;
         fetchY          <= (running && hActive && vActive) ? vCount : '0;
      end
   end

   assign fetchActive = fetchCtl.active;

   // Polarity is applied before the pipeline so its reset value is the idle bus level.
   assign pipeIn = '{active: fetchCtl.active,
                     hsync:  syncLevel(fetchCtl.hsync, SYNC_LOW),
                     vsync:  syncLevel(fetchCtl.vsync, SYNC_LOW)};

   signal_delay_line #(
      .WIDTH (VIDEO_CTL_W),
      .DEPTH (FETCH_LATENCY),
      .INIT  (PIPE_INIT)
   ) uDelay (
      .clock   (pixelClock),
      .resetN  (resetN),
      .dataIn  (pipeIn),
      .dataOut (pipeOut)
   );

   assign DE         = pipeOut.active;
   assign controlBus = {pipeOut.vsync, pipeOut.hsync};

   // Returned pixel data arrives in the same cycle as its delayed DE.
   assign redOut   = DE ? pixelIn[23:16] : 8'h00;
   assign greenOut = DE ? pixelIn[15:8]  : 8'h00;
   assign blueOut  = DE ? pixelIn[7:0]   : 8'h00;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator using reduced raster sizes: a cycle
// reference model, a start-up vector table and hand-written frame-boundary sequences.
module tb_video_timing_generator;

   // Instance 1: active-low syncs, latency 3, 15x8 raster (120-cycle frame)
   localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
   localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
   localparam int unsigned LAT = 3;

   logic        pixelClock = 1'b0;
   logic        resetN = 1'b0;
   logic        enable = 1'b0;
   logic        enable2 = 1'b0;
   logic [23:0] pixelIn;
   logic [23:0] pixelIn2 = 24'h5A3C96;
   logic [23:0] pixPipe [LAT];

   logic        fetchActive, frameStart, DE;
   logic [10:0] fetchX;
   logic [9:0]  fetchY;
   logic [1:0]  controlBus;
   logic [7:0]  redOut, greenOut, blueOut;

   logic        fetchActive2, frameStart2, DE2;
   logic [10:0] fetchX2;
   logic [9:0]  fetchY2;
   logic [1:0]  controlBus2;
   logic [7:0]  redOut2, greenOut2, blueOut2;

   int errors = 0;
   int checks = 0;

   always #5 pixelClock = ~pixelClock;

   // Frame source model: returns {column, row, A5} LAT cycles after each request.
   always @(posedge pixelClock) begin
      pixPipe[0] <= {fetchX[7:0], fetchY[7:0], 8'hA5};
      for (int i = 1; i < int'(LAT); i++) pixPipe[i] <= pixPipe[i-1];
   end
   assign pixelIn = pixPipe[LAT-1];

   video_timing_generator #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_LOW(1), .FETCH_LATENCY(LAT)
   ) dut (
      .pixelClock(pixelClock), .resetN(resetN), .enable(enable), .pixelIn(pixelIn),
      .fetchActive(fetchActive), .fetchX(fetchX), .fetchY(fetchY),
      .frameStart(frameStart), .DE(DE), .controlBus(controlBus),
      .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut)
   );

   // Instance 2: active-high syncs, latency 1, 18x7 raster (126-cycle frame)
   video_timing_generator #(
      .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
      .SYNC_ACTIVE_LOW(0), .FETCH_LATENCY(1)
   ) dut2 (
      .pixelClock(pixelClock), .resetN(resetN), .enable(enable2), .pixelIn(pixelIn2),
      .fetchActive(fetchActive2), .fetchX(fetchX2), .fetchY(fetchY2),
      .frameStart(frameStart2), .DE(DE2), .controlBus(controlBus2),
      .redOut(redOut2), .greenOut(greenOut2), .blueOut(blueOut2)
   );

   // Reference model state for instance 1
   bit mRun;
   int mh, mv;
   bit cFa, cFs, cHs, cVs;
   int cFx, cFy;
   bit hFa [LAT];
   bit hHs [LAT];
   bit hVs [LAT];
   int hFx [LAT];
   int hFy [LAT];

   // Frame statistics: running counts and values latched at each frameStart
   bit seen1, seen2;
   int c1Per, c1De, c1Hs, c1Vs, r1Per, r1De, r1Hs, r1Vs;
   int c2Per, c2De, c2Hs, c2Vs, c2Fa, r2Per, r2De, r2Hs, r2Vs, r2Fa;
   int stray2, maxX2, maxY2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelEdge();
      if (!resetN) begin
         mRun = 1'b0; mh = 0; mv = 0;
         cFa = 1'b0; cFs = 1'b0; cHs = 1'b0; cVs = 1'b0; cFx = 0; cFy = 0;
         for (int i = 0; i < int'(LAT); i++) begin
            hFa[i] = 1'b0; hHs[i] = 1'b0; hVs[i] = 1'b0; hFx[i] = 0; hFy[i] = 0;
         end
      end else begin
         for (int i = int'(LAT) - 1; i > 0; i--) begin
            hFa[i] = hFa[i-1]; hHs[i] = hHs[i-1]; hVs[i] = hVs[i-1];
            hFx[i] = hFx[i-1]; hFy[i] = hFy[i-1];
         end
         hFa[0] = cFa; hHs[0] = cHs; hVs[0] = cVs; hFx[0] = cFx; hFy[0] = cFy;
         cFa = mRun && mh < int'(HA) && mv < int'(VA);
         cHs = mRun && mh >= int'(HA + HF) && mh < int'(HA + HF + HS);
         cVs = mRun && mv >= int'(VA + VF) && mv < int'(VA + VF + VS);
         cFs = mRun && mh == 0 && mv == 0;
         cFx = cFa ? mh : 0;
         cFy = cFa ? mv : 0;
         if (!mRun) begin
            mRun = enable;
         end else if (mh == int'(HT) - 1) begin
            mh = 0;
            if (mv == int'(VT) - 1) begin
               mv = 0;
               mRun = enable;
            end else begin
               mv++;
            end
         end else begin
            mh++;
         end
      end
   endtask

   task automatic compareModel();
      bit eDe;
      eDe = hFa[LAT-1];
      check("fetchActive", 32'(fetchActive), 32'(cFa));
      check("frameStart",  32'(frameStart),  32'(cFs));
      check("fetchX",      32'(fetchX),      32'(cFx));
      check("fetchY",      32'(fetchY),      32'(cFy));
      check("DE",          32'(DE),          32'(eDe));
      check("controlBus",  32'(controlBus),  32'({~hVs[LAT-1], ~hHs[LAT-1]}));
      check("redOut",      32'(redOut),      eDe ? 32'(8'(hFx[LAT-1])) : 32'h0);
      check("greenOut",    32'(greenOut),    eDe ? 32'(8'(hFy[LAT-1])) : 32'h0);
      check("blueOut",     32'(blueOut),     eDe ? 32'h0A5 : 32'h0);
   endtask

   task automatic monitor();
      if (frameStart) begin
         if (seen1) begin r1Per = c1Per; r1De = c1De; r1Hs = c1Hs; r1Vs = c1Vs; end
         seen1 = 1'b1; c1Per = 0; c1De = 0; c1Hs = 0; c1Vs = 0;
      end
      c1Per++;
      if (DE) c1De++;
      if (!controlBus[0]) c1Hs++;
      if (!controlBus[1]) c1Vs++;
      if (frameStart2) begin
         if (seen2) begin r2Per = c2Per; r2De = c2De; r2Hs = c2Hs; r2Vs = c2Vs; r2Fa = c2Fa; end
         seen2 = 1'b1; c2Per = 0; c2De = 0; c2Hs = 0; c2Vs = 0; c2Fa = 0;
      end
      c2Per++;
      if (DE2) c2De++;
      if (fetchActive2) c2Fa++;
      if (controlBus2[0]) c2Hs++;
      if (controlBus2[1]) c2Vs++;
      if (!DE2 && ({redOut2, greenOut2, blueOut2} != 24'h0)) stray2++;
      if (int'(fetchX2) > maxX2) maxX2 = int'(fetchX2);
      if (int'(fetchY2) > maxY2) maxY2 = int'(fetchY2);
   endtask

   task automatic tick();
      @(posedge pixelClock);
      modelEdge();
      #1;
      compareModel();
      monitor();
   endtask

   task automatic waitPos(input int v, input int h, input string name);
      int n;
      n = 0;
      while (!(mRun && mv == v && mh == h) && n < 400) begin
         tick();
         n++;
      end
      check(name, 32'(n < 400), 32'(1));
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic       fa;
      logic       fs;
      logic       de;
      logic [1:0] ctrl;
      int         fx;
      int         red;
   } vec_t;

   initial begin
      vec_t tbl [9];
      int   deCnt, fsCnt;

      // Start-up: enable seen in IDLE -> fetch at +2, DE at +2+LAT with column-0 pixel
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0, 0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 0, 0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 0, 0};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1, 0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2, 0};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 3, 0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 4, 1};
      tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 5, 2};

      for (int i = 0; i < 9; i++) begin
         resetN  = tbl[i].rst;
         enable  = tbl[i].en;
         enable2 = tbl[i].en;
         tick();
         check($sformatf("vec%0d.fetchActive", i), 32'(fetchActive), 32'(tbl[i].fa));
         check($sformatf("vec%0d.frameStart", i),  32'(frameStart),  32'(tbl[i].fs));
         check($sformatf("vec%0d.DE", i),          32'(DE),          32'(tbl[i].de));
         check($sformatf("vec%0d.controlBus", i),  32'(controlBus),  32'(tbl[i].ctrl));
         check($sformatf("vec%0d.fetchX", i),      32'(fetchX),      32'(tbl[i].fx));
         check($sformatf("vec%0d.redOut", i),      32'(redOut),      32'(tbl[i].red));
         if (i == 0) check("reset.controlBus2", 32'(controlBus2), 32'h0);
      end

      // Steady running for three frames, then per-frame statistics
      for (int k = 0; k < 360; k++) tick();
      check("frame1.period",   32'(r1Per), 32'(120));
      check("frame1.deCycles", 32'(r1De),  32'(32));
      check("frame1.hsLow",    32'(r1Hs),  32'(24));
      check("frame1.vsLow",    32'(r1Vs),  32'(30));
      check("frame2.period",   32'(r2Per), 32'(126));
      check("frame2.deCycles", 32'(r2De),  32'(30));
      check("frame2.fetchCyc", 32'(r2Fa),  32'(30));
      check("frame2.hsHigh",   32'(r2Hs),  32'(28));
      check("frame2.vsHigh",   32'(r2Vs),  32'(18));
      check("frame2.stray",    32'(stray2), 32'(0));
      check("frame2.maxX",     32'(maxX2), 32'(9));
      check("frame2.maxY",     32'(maxY2), 32'(2));

      // Drop enable at line 2 with a short re-toggle: frame still completes, then IDLE
      waitPos(2, 0, "wait.line2");
      deCnt = 0;
      fsCnt = 0;
      for (int k = 0; k < 100; k++) begin
         enable = (k >= 4 && k < 7);
         tick();
         if (DE) deCnt++;
         if (frameStart) fsCnt++;
      end
      check("stop.remainingDE", 32'(deCnt), 32'(16));
      check("stop.noNewFrame",  32'(fsCnt), 32'(0));
      check("idle.fetchActive", 32'(fetchActive), 32'(0));
      check("idle.DE",          32'(DE), 32'(0));
      check("idle.controlBus",  32'(controlBus), 32'(2'b11));

      // Re-enable: frameStart exactly two cycles later
      enable = 1'b1;
      tick();
      check("restart.fs+1", 32'(frameStart), 32'(0));
      tick();
      check("restart.fs+2", 32'(frameStart), 32'(1));
      check("restart.fetchActive", 32'(fetchActive), 32'(1));

      // Reset mid-line while the pipeline holds visible pixels
      waitPos(1, 5, "wait.midline");
      check("preReset.DE", 32'(DE), 32'(1));
      resetN = 1'b0;
      tick();
      check("rst.fetchActive", 32'(fetchActive), 32'(0));
      check("rst.frameStart",  32'(frameStart), 32'(0));
      check("rst.fetchX",      32'(fetchX), 32'(0));
      check("rst.fetchY",      32'(fetchY), 32'(0));
      check("rst.DE",          32'(DE), 32'(0));
      check("rst.controlBus",  32'(controlBus), 32'(2'b11));
      check("rst.colour",      32'({redOut, greenOut, blueOut}), 32'(0));
      check("rst.controlBus2", 32'(controlBus2), 32'(2'b00));
      check("rst.DE2",         32'(DE2), 32'(0));
      resetN = 1'b1;
      enable = 1'b0;
      deCnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (DE) deCnt++;
      end
      check("flush.noDE", 32'(deCnt), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
